// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, constants and types for the 5-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 19;
    localparam int DATA_W  = 8;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 19'h0;

    // Source of the next fetch address, in decreasing priority.
    typedef enum logic [1:0] {
        NA_RESET    = 2'd0,
        NA_REDIRECT = 2'd1,
        NA_HOLD     = 2'd2,
        NA_SEQ      = 2'd3
    } next_src_e;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/stage1_pc_next_logic.sv
// ============================================================================
// Module      : pc_next_logic
// Description : Combinational redirect detection, target selection and
//               next-fetch-address computation for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_logic #(
    parameter int PC_W   = cpu_pkg::PC_W,
    parameter int DISP_W = cpu_pkg::DATA_W
) (
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_instr_valid,
    input  logic              i_pc_input_sel,
    input  logic              i_pc_adder_b_sel,
    input  logic [DISP_W-1:0] i_const_disp,
    input  logic [PC_W-1:0]   i_stack_out,
    input  logic [PC_W-1:0]   i_pc_out,
    input  logic [PC_W-1:0]   i_fpc,
    output logic              o_redirect,
    output logic [PC_W-1:0]   o_target,
    output logic [PC_W-1:0]   o_next_addr,
    output logic [PC_W-1:0]   o_stack_in
);

    import cpu_pkg::*;

    logic [PC_W-1:0] w_disp_ext;
    logic [PC_W-1:0] w_branch_tgt;
    next_src_e       w_src;

    assign w_disp_ext   = {{(PC_W-DISP_W){i_const_disp[DISP_W-1]}}, i_const_disp};
    assign w_branch_tgt = i_pc_out + w_disp_ext;

    // Return wins over a relative branch when the controller raises both.
    assign o_target   = i_pc_input_sel ? i_stack_out : w_branch_tgt;
    assign o_redirect = i_instr_valid & ~i_stall & (i_pc_input_sel | i_pc_adder_b_sel);
    assign o_stack_in = i_pc_out + PC_W'(1);

    always_comb begin
        w_src = NA_SEQ;
        if (i_rst) begin
            w_src = NA_RESET;
        end else if (o_redirect) begin
            w_src = NA_REDIRECT;
        end else if (i_stall) begin
            w_src = NA_HOLD;
        end
    end

    always_comb begin
        o_next_addr = i_fpc + PC_W'(1);
        case (w_src)
            NA_RESET:    o_next_addr = '0;
            NA_REDIRECT: o_next_addr = o_target;
            NA_HOLD:     o_next_addr = i_fpc;
            NA_SEQ:      o_next_addr = i_fpc + PC_W'(1);
            default:     o_next_addr = i_fpc + PC_W'(1);
        endcase
    end

endmodule : pc_next_logic

`default_nettype wire

// File: rtl/stage1.sv
// ============================================================================
// Module      : stage1
// Description : Instruction-fetch stage: PC, synchronous ROM addressing and
//               the IF/ID register. Optional counters: STAGE1_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage1 #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        pcAdderInputBSel,
    input  logic                        pcInputSel,
    input  logic [cpu_pkg::DATA_W-1:0]  const_disp,
    input  logic [PC_W-1:0]             stackOut,
    output logic [PC_W-1:0]             imemAddr,
    input  logic [INSTR_W-1:0]          imemData,
    output logic [INSTR_W-1:0]          instruction,
    output logic                        instrValid,
    output logic [PC_W-1:0]             pcOut,
    output logic [PC_W-1:0]             stackIn
`ifdef STAGE1_PERF_CNT_EN
   ,output logic [15:0]                 fetchCount,
    output logic [15:0]                 bubbleCount
`endif
);

    import cpu_pkg::*;

    logic [PC_W-1:0]    r_fpc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;
    logic               r_valid;

    logic               w_redirect;
    logic [PC_W-1:0]    w_target;
    logic [PC_W-1:0]    w_next_addr;
    logic [PC_W-1:0]    w_stack_in;

    pc_next_logic #(
        .PC_W   (PC_W),
        .DISP_W (DATA_W)
    ) u_pc_next (
        .i_rst            (rst),
        .i_stall          (stall),
        .i_instr_valid    (r_valid),
        .i_pc_input_sel   (pcInputSel),
        .i_pc_adder_b_sel (pcAdderInputBSel),
        .i_const_disp     (const_disp),
        .i_stack_out      (stackOut),
        .i_pc_out         (r_pc),
        .i_fpc            (r_fpc),
        .o_redirect       (w_redirect),
        .o_target         (w_target),
        .o_next_addr      (w_next_addr),
        .o_stack_in       (w_stack_in)
    );

    assign imemAddr    = w_next_addr;
    assign instruction = r_instr;
    assign instrValid  = r_valid;
    assign pcOut       = r_pc;
    assign stackIn     = w_stack_in;

    // fpc tracks the address the ROM captured, so it always names imemData.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc <= '0;
        end else begin
            r_fpc <= w_next_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (stall) begin
            r_instr <= r_instr;
            r_pc    <= r_pc;
            r_valid <= r_valid;
        end else if (w_redirect) begin
            // The word on imemData is the wrong-path fetch; squash it.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else begin
            r_instr <= imemData;
            r_pc    <= r_fpc;
            r_valid <= 1'b1;
        end
    end

`ifdef STAGE1_PERF_CNT_EN
    logic        w_load_valid;
    logic        w_load_bubble;
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_bubble_cnt;

    assign w_load_valid  = ~flush & ~stall & ~w_redirect;
    assign w_load_bubble = flush | (~stall & w_redirect);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_load_valid && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_load_bubble && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign fetchCount  = r_fetch_cnt;
    assign bubbleCount = r_bubble_cnt;
`endif

endmodule : stage1

`default_nettype wire

// File: tb/tb_stage1.sv
// ============================================================================
// Module      : tb_stage1
// Description : Scoreboard bench for stage1 with a synchronous ROM model and
//               a transaction-level reference model of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pcAdderInputBSel = 1'b0;
    logic        pcInputSel = 1'b0;
    logic [7:0]  const_disp = 8'h0;
    logic [11:0] stackOut = 12'h0;
    logic [11:0] imemAddr;
    logic [18:0] imemData = 19'h0;
    logic [18:0] instruction;
    logic        instrValid;
    logic [11:0] pcOut;
    logic [11:0] stackIn;
`ifdef STAGE1_PERF_CNT_EN
    logic [15:0] fetchCount;
    logic [15:0] bubbleCount;
`endif

    stage1 dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .pcAdderInputBSel (pcAdderInputBSel),
        .pcInputSel       (pcInputSel),
        .const_disp       (const_disp),
        .stackOut         (stackOut),
        .imemAddr         (imemAddr),
        .imemData         (imemData),
        .instruction      (instruction),
        .instrValid       (instrValid),
        .pcOut            (pcOut),
        .stackIn          (stackIn)
`ifdef STAGE1_PERF_CNT_EN
       ,.fetchCount       (fetchCount),
        .bubbleCount      (bubbleCount)
`endif
    );

    always #5 clk = ~clk;

    logic [18:0] mem [4096];
    always @(posedge clk) imemData <= mem[imemAddr];

    typedef struct {
        int instr;
        int valid;
        int pc;
        bit pc_chk;
        int addr;
        int fcnt;
        int bcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: what the IF/ID register holds, which fetch address the
    // ROM data currently belongs to, and whether pcOut is defined.
    int m_fpc = 0, m_instr = 0, m_valid = 0, m_pc = 0;
    bit m_pc_known = 1'b1;
    int m_fcnt = 0, m_bcnt = 0;

    function automatic int wrap(input int v);
        return ((v % 4096) + 4096) % 4096;
    endfunction

    function automatic int sdisp(input logic [7:0] d);
        return (int'(d) >= 128) ? int'(d) - 256 : int'(d);
    endfunction

    function automatic bit m_redirect(input bit s, input bit pb, input bit ps);
        return (m_valid != 0) && !s && (pb || ps);
    endfunction

    function automatic int m_addr(input bit r, input bit s, input bit pb, input bit ps,
                                  input logic [7:0] d, input logic [11:0] so);
        if (r) return 0;
        if (m_redirect(s, pb, ps)) return ps ? int'(so) : wrap(m_pc + sdisp(d));
        if (s) return m_fpc;
        return wrap(m_fpc + 1);
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit f, input bit pb,
                              input bit ps, input logic [7:0] d, input logic [11:0] so);
        int  nxt;
        bit  redir;
        nxt   = m_addr(r, s, pb, ps, d, so);
        redir = m_redirect(s, pb, ps);
        if (r) begin
            m_instr = 0; m_pc = 0; m_valid = 0; m_pc_known = 1'b1;
            m_fcnt = 0; m_bcnt = 0;
        end else if (f) begin
            m_instr = 0; m_valid = 0;
            if (m_bcnt < 65535) m_bcnt++;
        end else if (s) begin
            // IF/ID unchanged
        end else if (redir) begin
            m_instr = 0; m_valid = 0; m_pc_known = 1'b0;
            if (m_bcnt < 65535) m_bcnt++;
        end else begin
            m_instr = int'(mem[m_fpc]); m_pc = m_fpc; m_valid = 1; m_pc_known = 1'b1;
            if (m_fcnt < 65535) m_fcnt++;
        end
        m_fpc = nxt;
    endtask

    // Apply one cycle of inputs, queue the expected outputs for it, then
    // advance the model across the edge.
    task automatic cycle(input bit chk, input bit r, input bit s, input bit f,
                         input bit pb, input bit ps, input logic [7:0] d,
                         input logic [11:0] so);
        exp_t e;
        rst = r; stall = s; flush = f;
        pcAdderInputBSel = pb; pcInputSel = ps; const_disp = d; stackOut = so;
        if (chk) begin
            e.instr = m_instr; e.valid = m_valid; e.pc = m_pc; e.pc_chk = m_pc_known;
            e.addr = m_addr(r, s, pb, ps, d, so); e.fcnt = m_fcnt; e.bcnt = m_bcnt;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        model_edge(r, s, f, pb, ps, d, so);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    endtask

    task automatic run_to_pc(input int target);
        int budget;
        budget = 0;
        while (!(m_valid != 0 && m_pc == target) && budget < 200) begin
            idle(1);
            budget++;
        end
        if (budget >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL run_to_pc: pcOut never reached %03h (model pc %03h)", target, m_pc);
        end
    endtask

    function automatic void check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instruction", int'(instruction), e.instr);
            check("instrValid", int'(instrValid), e.valid);
            check("imemAddr", int'(imemAddr), e.addr);
            if (e.pc_chk) begin
                check("pcOut", int'(pcOut), e.pc);
                check("stackIn", int'(stackIn), wrap(e.pc + 1));
            end
`ifdef STAGE1_PERF_CNT_EN
            check("fetchCount", int'(fetchCount), e.fcnt);
            check("bubbleCount", int'(bubbleCount), e.bcnt);
`endif
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = {7'($urandom), 12'(i)};

        @(posedge clk);
        #1;
        cycle(1'b0, 1, 0, 0, 0, 0, 8'h00, 12'h000);
        cycle(1'b1, 1, 0, 0, 0, 0, 8'h00, 12'h000);

        idle(3);
        run_to_pc(5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1, 0, 0, 0, 8'h00, 12'h000);
        idle(2);

        run_to_pc(16);
        cycle(1'b1, 0, 0, 0, 1, 0, 8'hFC, 12'h000);
        idle(3);

        cycle(1'b1, 0, 0, 0, 1, 1, 8'h05, 12'h123);
        idle(3);

        cycle(1'b1, 0, 0, 0, 0, 1, 8'h00, 12'hFFA);
        idle(12);

        cycle(1'b1, 0, 1, 0, 1, 0, 8'h10, 12'h000);
        cycle(1'b1, 0, 1, 0, 1, 0, 8'h10, 12'h000);
        cycle(1'b1, 0, 0, 0, 1, 0, 8'h10, 12'h000);
        idle(2);
        cycle(1'b1, 0, 1, 1, 0, 0, 8'h00, 12'h000);
        cycle(1'b1, 0, 0, 1, 0, 0, 8'h00, 12'h000);
        idle(3);

        cycle(1'b1, 0, 1, 0, 1, 1, 8'h00, 12'h456);
        cycle(1'b1, 1, 1, 0, 1, 1, 8'h00, 12'h456);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            cycle(1'b1,
                  ($urandom_range(63) == 0),
                  ($urandom_range(4) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(5) == 0),
                  ($urandom_range(7) == 0),
                  8'($urandom), 12'($urandom));
        end
        idle(2);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stage1

`default_nettype wire
